ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Initiator/controller for the simple async-read, sync-write RAM (DEPTH x DATA_W).
//  Accepts read/write requests over a valid/ready port and drives the RAM's
//  addr/wraddr/wrdata ports. Reads return data on a registered, back-pressurable
//  response port. It also fills the RAM in hardware, so synthesis needs no initial block.
//  It sits between a client (CPU/test sequencer) and the RAM instance.
// PARAMETERS
//  ADDR_W  5   request/RAM address width
//  DATA_W  4   data width
//  DEPTH   16  number of implemented words; addresses >= DEPTH are out of range
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  rst         in   1       asynchronous, active-high reset
//  fill_start  in   1       pulse in IDLE: refill RAM with the index pattern
//  busy        out  1       1 while not in IDLE
//  fill_done   out  1       one-cycle pulse when the last fill write is issued
//  req_valid   in   1       request valid
//  req_ready   out  1       request accepted when req_valid & req_ready
//  req_write   in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  word address
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       read response valid; held until rsp_ready
//  rsp_ready   in   1       response consumer ready
//  rsp_data    out  DATA_W  read data (0 when rsp_err)
//  rsp_err     out  1       read address was out of range
//  mem_addr    out  ADDR_W  to RAM read address (registered)
//  mem_rdata   in   DATA_W  from RAM read data (combinational)
//  mem_we      out  1       write strobe (registered); RAM wrapper gates the write with it
//  mem_wraddr  out  ADDR_W  to RAM write address (registered)
//  mem_wrdata  out  DATA_W  to RAM write data (registered)
// BEHAVIOUR
//  States: FILL, IDLE, WR, RD, RESP.
//  Reset values: state=FILL, fill idx=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_we=0,
//  mem_addr=0, mem_wraddr=0, mem_wrdata=0, fill_done=0. busy=1 and req_ready=0 during reset.
//  req_ready = (state==IDLE) & ~fill_start. fill_start has priority over a same-cycle request.
//  FILL:
//   - One write per cycle: mem_we=1, mem_wraddr=idx, mem_wrdata=idx[DATA_W-1:0], idx 0..DEPTH-1.
//   - fill_done pulses with the idx=DEPTH-1 write; the next state is IDLE.
//   - Fill takes exactly DEPTH cycles.
//  IDLE:
//   - fill_start -> FILL with idx=0.
//   - Accepted write -> WR. Accepted read -> RD with mem_addr<=req_addr.
//  WR (1 cycle):
//   - In range: mem_we=1, mem_wraddr/mem_wrdata hold the captured request.
//   - Out of range: mem_we=0 and the write is silently dropped.
//   - Next state is IDLE. Write throughput is 1 per 2 cycles; writes get no response.
//  RD (1 cycle):
//   - Sample mem_rdata at the clock edge into rsp_data; rsp_valid<=1; go to RESP.
//   - Out of range: rsp_data<=0, rsp_err<=1, and the RAM value is ignored.
//  RESP:
//   - rsp_valid/rsp_data/rsp_err stay stable until rsp_ready.
//   - On the rsp_ready cycle: rsp_valid<=0, rsp_err<=0, go to IDLE.
//   - Read latency from accept to rsp_valid is 2 cycles.
//  mem_we is 0 in every state other than FILL and an in-range WR.
//  No wrap-around: address bits are never truncated to index the RAM.
//  Reset mid-operation: any pending response or write is dropped; fill restarts at idx 0.
// TESTING
//  1. Reset release -> 16 cycles of mem_we=1 with wraddr 0..15 and wrdata = addr; fill_done
//     pulses once with wraddr=15; then read addr 9 -> rsp_data=4'h9 two cycles after accept.
//  2. Write addr 3 data 4'hA, then read addr 3 -> rsp_data=4'hA, rsp_err=0.
//  3. Write addr 20 -> mem_we stays 0; read addr 20 -> rsp_err=1, rsp_data=0.
//  4. Read addr 5 with rsp_ready low for 3 cycles -> rsp_valid=1, rsp_data=4'h5 stable and
//     req_ready=0 throughout; IDLE returns the cycle after rsp_ready=1.
//  5. rst asserted during fill at idx 7 -> outputs return to reset values immediately;
//     after release, a full 16-write fill from idx 0.
//  6. fill_start and req_valid (read addr 2) in the same IDLE cycle -> req_ready=0, fill runs;
//     the read is accepted after fill_done and returns 4'h2.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Request/response controller for an async-read, sync-write RAM.
// Fills the RAM with its index pattern after reset or on fill_start.
module ram_access_ctrl #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_start,
   output logic              busy,
   output logic              fill_done,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_wraddr,
   output logic [DATA_W-1:0] mem_wrdata
);

   typedef enum logic [2:0] {StFill, StIdle, StWr, StRd, StResp} state_t;

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]   DepthX  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_wraddr_q, mem_wraddr_d;
   logic [DATA_W-1:0]   mem_wrdata_q, mem_wrdata_d;
   logic                fill_done_q, fill_done_d;
   logic                accept;
   logic                req_in_range;
   logic                rd_in_range;

   assign req_ready    = (state_q == StIdle) & ~fill_start;
   assign busy         = (state_q != StIdle);
   assign accept       = req_valid & req_ready;
   assign req_in_range = {1'b0, req_addr} < DepthX;
   assign rd_in_range  = {1'b0, mem_addr_q} < DepthX;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wraddr_d = mem_wraddr_q;
      mem_wrdata_d = mem_wrdata_q;
      fill_done_d  = 1'b0;
      unique case (state_q)
         StFill: begin
            mem_we_d     = 1'b1;
            mem_wraddr_d = idx_q;
            mem_wrdata_d = DATA_W'(idx_q);
            if (idx_q == LastIdx) begin
               fill_done_d = 1'b1;
               idx_d       = '0;
               state_d     = StIdle;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StIdle: begin
            if (fill_start) begin
               idx_d   = '0;
               state_d = StFill;
            end else if (accept) begin
               if (req_write) begin
                  // Out-of-range writes still visit WR but never strobe the RAM.
                  mem_we_d     = req_in_range;
                  mem_wraddr_d = req_addr;
                  mem_wrdata_d = req_wdata;
                  state_d      = StWr;
               end else begin
                  mem_addr_d = req_addr;
                  state_d    = StRd;
               end
            end
         end
         StWr: state_d = StIdle;
         StRd: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_in_range ? mem_rdata : '0;
            rsp_err_d   = ~rd_in_range;
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StFill;
         idx_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wraddr_q <= '0;
         mem_wrdata_q <= '0;
         fill_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wraddr_q <= mem_wraddr_d;
         mem_wrdata_q <= mem_wrdata_d;
         fill_done_q  <= fill_done_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wraddr = mem_wraddr_q;
   assign mem_wrdata = mem_wrdata_q;
   assign fill_done  = fill_done_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural 16x4 RAM attached.
module tb_ram_access_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       fill_start;
   logic       busy;
   logic       fill_done;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [4:0] req_addr;
   logic [3:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_err;
   logic [4:0] mem_addr;
   logic [3:0] mem_rdata;
   logic       mem_we;
   logic [4:0] mem_wraddr;
   logic [3:0] mem_wrdata;

   always #5 clk = ~clk;

   ram_access_ctrl #(.ADDR_W(5), .DATA_W(4), .DEPTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .fill_start (fill_start),
      .busy       (busy),
      .fill_done  (fill_done),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_we     (mem_we),
      .mem_wraddr (mem_wraddr),
      .mem_wrdata (mem_wrdata)
   );

   // Out-of-range reads return all-ones so a missing zero mask shows up.
   logic [3:0] ram [16];
   assign mem_rdata = (mem_addr < 5'd16) ? ram[mem_addr[3:0]] : 4'hF;
   always @(posedge clk) begin
      if (mem_we && mem_wraddr < 5'd16) ram[mem_wraddr[3:0]] <= mem_wrdata;
   end

   int total = 0;
   int bad = 0;
   int fill_done_seen = 0;
   logic [4:0] rq [$];
   logic [9:0] wq [$];
   logic [9:0] wexp;
   logic [4:0] rexp;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: event missing or unexpected at %0t", name, $time);
   endtask

   // Expected write: {fill_done, wraddr, wrdata}; expected response: {rsp_err, rsp_data}.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            if (wq.size() == 0) begin
               fail("unexpected_write");
            end else begin
               wexp = wq.pop_front();
               check("write", {fill_done, mem_wraddr, mem_wrdata}, wexp);
            end
         end else if (fill_done) begin
            fail("fill_done_without_write");
         end
         if (fill_done) fill_done_seen++;
         if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) begin
               fail("unexpected_rsp");
            end else begin
               rexp = rq.pop_front();
               check("rsp", {rsp_err, rsp_data}, rexp);
            end
         end
      end
   end

   task automatic push_fill();
      for (int i = 0; i < 16; i++) wq.push_back({i == 15, 5'(i), 4'(i)});
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
      end
      if (!ok) fail("accept_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
      if (!ok) fail("idle_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [4:0] a, input logic [3:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      wait_accept();
      req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      fill_start = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", {mem_we, rsp_valid, fill_done, rsp_err, busy, req_ready}, 6'b000010);
      check("reset_data", {mem_addr, mem_wraddr, mem_wrdata, rsp_data}, 18'h0);

      // 1: fill after reset, then read 9 with two-cycle latency
      push_fill();
      @(negedge clk);
      rst = 1'b0;
      wait_idle();
      rq.push_back({1'b0, 4'h9});
      issue(1'b0, 5'd9, 4'h0);
      @(negedge clk);
      check("rd_lat_rd", rsp_valid, 1'b0);
      @(negedge clk);
      check("rd_lat_resp", rsp_valid, 1'b1);
      wait_idle();

      // 2: write then read back
      wq.push_back({1'b0, 5'd3, 4'hA});
      issue(1'b1, 5'd3, 4'hA);
      @(negedge clk);
      check("wr_busy", busy, 1'b1);
      wait_idle();
      rq.push_back({1'b0, 4'hA});
      issue(1'b0, 5'd3, 4'h0);
      wait_idle();

      // 3: out-of-range write dropped, out-of-range read flagged
      issue(1'b1, 5'd20, 4'h5);
      @(negedge clk);
      check("oor_we", mem_we, 1'b0);
      wait_idle();
      rq.push_back({1'b1, 4'h0});
      issue(1'b0, 5'd20, 4'h0);
      wait_idle();

      // 4: response back-pressure for 3 cycles
      rsp_ready = 1'b0;
      rq.push_back({1'b0, 4'h5});
      issue(1'b0, 5'd5, 4'h0);
      @(negedge clk);
      check("bp_rd_cycle", rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_data", rsp_data, 4'h5);
         check("bp_req_ready", req_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_idle", {busy, req_ready, rsp_valid}, 3'b010);

      // 5: reset in the middle of a fill
      @(negedge clk);
      rst = 1'b1;
      push_fill();
      @(negedge clk);
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_ctrl", {mem_we, fill_done, busy, req_ready, rsp_valid}, 5'b00100);
      check("midrst_data", {mem_wraddr, mem_wrdata}, 9'h0);
      wq.delete();
      push_fill();
      @(negedge clk);
      rst = 1'b0;
      wait_idle();

      // 6: fill_start beats a same-cycle read request
      rq.push_back({1'b0, 4'h2});
      push_fill();
      fill_start = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr = 5'd2;
      #1;
      check("fs_prio_ready", req_ready, 1'b0);
      @(posedge clk);
      #1;
      fill_start = 1'b0;
      check("fs_busy", busy, 1'b1);
      wait_accept();
      req_valid = 1'b0;
      check("fs_after_done", fill_done_seen, 3);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      check("rq_drained", rq.size(), 0);
      check("wq_drained", wq.size(), 0);
      check("fill_done_count", fill_done_seen, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
